ctrl_pipeline: RTL and testbench

Pipelined control and hazard block for the 5-stage RV32I core. It decodes the instruction in Decode and carries the resulting control word through the ID/EX, EX/MEM and MEM/WB registers, so the datapath receives stage-aligned controls. It also generates load-use stalls, branch/jump flushes and EX-stage forwarding selects. The ALU control width is widened and an optional M-extension decode is added, replacing the earlier decode-only control unit.

---
 rtl/ctrl_pkg.sv | 111 +++++++++++
 rtl/ctrl_pipeline_if.sv | 41 ++++
 rtl/rv_decoder.sv | 127 ++++++++++++
 rtl/ctrl_pipeline.sv | 93 +++++++++
 tb/tb_ctrl_pipeline.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline control block:
// ALU codes, decode control word, pipeline register layouts, forwarding helper.
package ctrl_pkg;

   localparam int ALU_W = 4;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLTU  = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRL   = 4'd8,
      ALU_SRA   = 4'd9,
      ALU_MUL   = 4'd10,
      ALU_PASSB = 4'd11
   } alu_ctrl_t;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [1:0] result_src;
      logic       mem_write;
      alu_ctrl_t  alu_ctrl;
      logic       alu_src;
      logic [2:0] imm_src;
      logic       reg_write;
      logic       jump_src;
      logic       a_type;
      logic       jump;
      logic       branch;
      logic       illegal;
   } ctrl_word_t;

   localparam ctrl_word_t BUBBLE = '{
      result_src: RES_ALU, mem_write: 1'b0, alu_ctrl: ALU_ADD, alu_src: 1'b0,
      imm_src: IMM_I, reg_write: 1'b0, jump_src: 1'b0, a_type: 1'b0,
      jump: 1'b0, branch: 1'b0, illegal: 1'b0
   };

   typedef struct packed {
      ctrl_word_t ctrl;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } id_ex_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_write;
      logic [1:0] result_src;
   } ex_mem_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic [1:0] result_src;
   } mem_wb_t;

   localparam id_ex_t ID_EX_RST = '{
      ctrl: BUBBLE, funct3: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
   };
   localparam ex_mem_t EX_MEM_RST = '{
      rd: 5'd0, reg_write: 1'b0, mem_write: 1'b0, result_src: RES_ALU
   };
   localparam mem_wb_t MEM_WB_RST = '{
      rd: 5'd0, reg_write: 1'b0, result_src: RES_ALU
   };

   // MEM result is newer than WB, so it wins; x0 is hardwired and never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       rw_m,
                                          input logic [4:0] rd_m,
                                          input logic       rw_w,
                                          input logic [4:0] rd_w);
      if (rw_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (rw_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decode-side instruction/branch inputs and stage-aligned control outputs
// of the pipeline control block.
interface ctrl_pipeline_if #(
   parameter int WIDTH      = 32,
   parameter int ALU_CTRL_W = 4
);
   logic [WIDTH-1:0]      instr_d;
   logic                  pc_src_e;
   logic [2:0]            imm_src_d;
   logic [ALU_CTRL_W-1:0] alu_ctrl_e;
   logic                  alu_src_e;
   logic                  a_type_e;
   logic                  jump_src_e;
   logic                  branch_e;
   logic                  jump_e;
   logic [2:0]            funct3_e;
   logic                  mem_write_m;
   logic [1:0]            result_src_w;
   logic                  reg_write_w;
   logic                  stall_f;
   logic                  stall_d;
   logic                  flush_d;
   logic                  flush_e;
   logic [1:0]            forward_a_e;
   logic [1:0]            forward_b_e;
   logic                  illegal_e;

   modport master (
      output instr_d, pc_src_e,
      input  imm_src_d, alu_ctrl_e, alu_src_e, a_type_e, jump_src_e, branch_e,
             jump_e, funct3_e, mem_write_m, result_src_w, reg_write_w, stall_f,
             stall_d, flush_d, flush_e, forward_a_e, forward_b_e, illegal_e
   );

   modport slave (
      input  instr_d, pc_src_e,
      output imm_src_d, alu_ctrl_e, alu_src_e, a_type_e, jump_src_e, branch_e,
             jump_e, funct3_e, mem_write_m, result_src_w, reg_write_w, stall_f,
             stall_d, flush_d, flush_e, forward_a_e, forward_b_e, illegal_e
   );
endinterface

// File: rtl/rv_decoder.sv
// RV32I (+ optional MUL) instruction decoder: instruction word to control word.
// Anything unrecognised becomes a bubble with the illegal flag set.
module rv_decoder
   import ctrl_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [WIDTH-1:0] instr,
   output ctrl_word_t       ctrl
);
   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       legal;
   ctrl_word_t c;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      c     = BUBBLE;
      legal = 1'b1;
      case (opcode)
         OP_R: begin
            c.reg_write = 1'b1;
            case ({funct7, funct3})
               {7'b0000000, 3'b000}: c.alu_ctrl = ALU_ADD;
               {7'b0100000, 3'b000}: c.alu_ctrl = ALU_SUB;
               {7'b0000000, 3'b001}: c.alu_ctrl = ALU_SLL;
               {7'b0000000, 3'b010}: c.alu_ctrl = ALU_SLT;
               {7'b0000000, 3'b011}: c.alu_ctrl = ALU_SLTU;
               {7'b0000000, 3'b100}: c.alu_ctrl = ALU_XOR;
               {7'b0000000, 3'b101}: c.alu_ctrl = ALU_SRL;
               {7'b0100000, 3'b101}: c.alu_ctrl = ALU_SRA;
               {7'b0000000, 3'b110}: c.alu_ctrl = ALU_OR;
               {7'b0000000, 3'b111}: c.alu_ctrl = ALU_AND;
               {7'b0000001, 3'b000}: begin
                  if (ENABLE_M) c.alu_ctrl = ALU_MUL;
                  else          legal      = 1'b0;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_I: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.imm_src   = IMM_I;
            case (funct3)
               3'b000: c.alu_ctrl = ALU_ADD;
               3'b010: c.alu_ctrl = ALU_SLT;
               3'b011: c.alu_ctrl = ALU_SLTU;
               3'b100: c.alu_ctrl = ALU_XOR;
               3'b110: c.alu_ctrl = ALU_OR;
               3'b111: c.alu_ctrl = ALU_AND;
               3'b001: begin
                  if (funct7 == 7'b0000000) c.alu_ctrl = ALU_SLL;
                  else                      legal      = 1'b0;
               end
               default: begin
                  if (funct7 == 7'b0000000)      c.alu_ctrl = ALU_SRL;
                  else if (funct7 == 7'b0100000) c.alu_ctrl = ALU_SRA;
                  else                           legal      = 1'b0;
               end
            endcase
         end
         OP_LOAD: begin
            c.reg_write  = 1'b1;
            c.alu_src    = 1'b1;
            c.imm_src    = IMM_I;
            c.result_src = RES_MEM;
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) legal = 1'b0;
         end
         OP_STORE: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
            c.imm_src   = IMM_S;
            if (funct3[2] || funct3 == 3'b011) legal = 1'b0;
         end
         OP_BRANCH: begin
            c.branch   = 1'b1;
            c.imm_src  = IMM_B;
            c.alu_ctrl = ALU_SUB;
            if (funct3 == 3'b010 || funct3 == 3'b011) legal = 1'b0;
         end
         OP_JAL: begin
            c.jump       = 1'b1;
            c.reg_write  = 1'b1;
            c.imm_src    = IMM_J;
            c.result_src = RES_PC4;
         end
         OP_JALR: begin
            // target comes from the ALU (rs1 + imm) rather than PC + imm
            c.jump       = 1'b1;
            c.jump_src   = 1'b1;
            c.reg_write  = 1'b1;
            c.alu_src    = 1'b1;
            c.imm_src    = IMM_I;
            c.result_src = RES_PC4;
            if (funct3 != 3'b000) legal = 1'b0;
         end
         OP_LUI: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.imm_src   = IMM_U;
            c.alu_ctrl  = ALU_PASSB;
         end
         OP_AUIPC: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
            c.a_type    = 1'b1;
            c.imm_src   = IMM_U;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         c         = BUBBLE;
         c.illegal = 1'b1;
      end
   end

   assign ctrl = c;

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipelined control/hazard unit: carries decoded controls through ID/EX, EX/MEM
// and MEM/WB and produces load-use stalls, branch flushes and EX forward selects.
module ctrl_pipeline
   import ctrl_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ALU_CTRL_W = 4,
   parameter bit ENABLE_M   = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   ctrl_pipeline_if.slave bus
);
   ctrl_word_t dec_ctrl;
   id_ex_t     id_ex_d, id_ex_q;
   ex_mem_t    ex_mem_d, ex_mem_q;
   mem_wb_t    mem_wb_d, mem_wb_q;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       load_use;
   logic       flush_e;
   logic       unused_imm;

   rv_decoder #(
      .WIDTH    (WIDTH),
      .ENABLE_M (ENABLE_M)
   ) u_dec (
      .instr (bus.instr_d),
      .ctrl  (dec_ctrl)
   );

   assign rs1_d = bus.instr_d[19:15];
   assign rs2_d = bus.instr_d[24:20];
   assign rd_d  = bus.instr_d[11:7];

   assign load_use = (id_ex_q.ctrl.result_src == RES_MEM) && (id_ex_q.rd != 5'd0) &&
                     ((id_ex_q.rd == rs1_d) || (id_ex_q.rd == rs2_d));
   assign flush_e  = load_use || bus.pc_src_e;

   always_comb begin
      id_ex_d = ID_EX_RST;
      if (!flush_e) begin
         id_ex_d.ctrl   = dec_ctrl;
         id_ex_d.funct3 = bus.instr_d[14:12];
         id_ex_d.rs1    = rs1_d;
         id_ex_d.rs2    = rs2_d;
         id_ex_d.rd     = rd_d;
      end
      ex_mem_d = '{rd: id_ex_q.rd, reg_write: id_ex_q.ctrl.reg_write,
                   mem_write: id_ex_q.ctrl.mem_write, result_src: id_ex_q.ctrl.result_src};
      mem_wb_d = '{rd: ex_mem_q.rd, reg_write: ex_mem_q.reg_write,
                   result_src: ex_mem_q.result_src};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_q  <= ID_EX_RST;
         ex_mem_q <= EX_MEM_RST;
         mem_wb_q <= MEM_WB_RST;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   // imm_src is consumed in Decode only; the EX copy is carried but not used
   assign unused_imm = ^id_ex_q.ctrl.imm_src;

   assign bus.imm_src_d    = dec_ctrl.imm_src;
   assign bus.alu_ctrl_e   = ALU_CTRL_W'(id_ex_q.ctrl.alu_ctrl);
   assign bus.alu_src_e    = id_ex_q.ctrl.alu_src;
   assign bus.a_type_e     = id_ex_q.ctrl.a_type;
   assign bus.jump_src_e   = id_ex_q.ctrl.jump_src;
   assign bus.branch_e     = id_ex_q.ctrl.branch;
   assign bus.jump_e       = id_ex_q.ctrl.jump;
   assign bus.funct3_e     = id_ex_q.funct3;
   assign bus.illegal_e    = id_ex_q.ctrl.illegal;
   assign bus.mem_write_m  = ex_mem_q.mem_write;
   assign bus.result_src_w = mem_wb_q.result_src;
   assign bus.reg_write_w  = mem_wb_q.reg_write;

   // a coinciding branch flush cancels the stall so the wrong-path fetch is dropped
   assign bus.stall_f = load_use && !bus.pc_src_e;
   assign bus.stall_d = load_use && !bus.pc_src_e;
   assign bus.flush_d = bus.pc_src_e;
   assign bus.flush_e = flush_e;

   assign bus.forward_a_e = fwd_sel(id_ex_q.rs1, ex_mem_q.reg_write, ex_mem_q.rd,
                                    mem_wb_q.reg_write, mem_wb_q.rd);
   assign bus.forward_b_e = fwd_sel(id_ex_q.rs2, ex_mem_q.reg_write, ex_mem_q.rd,
                                    mem_wb_q.reg_write, mem_wb_q.rd);

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: expectations are queued with the cycle they
// fall due when an instruction is driven, and checked on the falling edge.
module tb_ctrl_pipeline;

   typedef enum logic [4:0] {
      F_IMM, F_ALU, F_ALU_SRC, F_ATYPE, F_JSRC, F_BR, F_JMP, F_F3, F_MW, F_RS,
      F_RW, F_STF, F_STD, F_FLD, F_FLE, F_FWA, F_FWB, F_ILL
   } fld_e;

   typedef struct packed {
      int         due;
      logic       sel;
      fld_e       fld;
      logic [7:0] exp;
   } item_t;

   localparam logic [31:0] I_NOP     = 32'h00000013;
   localparam logic [31:0] I_ADD_X3  = 32'h002081B3;
   localparam logic [31:0] I_LW_X5   = 32'h0000A283;
   localparam logic [31:0] I_ADD_X6  = 32'h00228333;
   localparam logic [31:0] I_ADD_X4  = 32'h00208233;
   localparam logic [31:0] I_SUB_X7  = 32'h404203B3;
   localparam logic [31:0] I_BEQ     = 32'h00208463;
   localparam logic [31:0] I_ADD_X9  = 32'h002084B3;
   localparam logic [31:0] I_MUL     = 32'h023100B3;
   localparam logic [31:0] I_SW      = 32'h0020A023;
   localparam logic [31:0] I_LUI     = 32'h123452B7;
   localparam logic [31:0] I_JAL     = 32'h010000EF;
   localparam logic [31:0] I_JALR    = 32'h000100E7;
   localparam logic [31:0] I_AUIPC   = 32'h00001197;
   localparam logic [31:0] I_BAD     = 32'hFFFFFFFF;
   localparam logic [31:0] I_ADD_X0  = 32'h00208033;
   localparam logic [31:0] I_ADD_X5Z = 32'h000002B3;
   localparam logic [31:0] I_LW_X0   = 32'h0000A003;
   localparam logic [31:0] I_ADD_X6Z = 32'h00000333;

   logic  clk = 1'b0;
   logic  rst;
   int    cyc = 0;
   int    checks = 0;
   int    passed = 0;
   item_t sb[$];

   ctrl_pipeline_if b0 ();
   ctrl_pipeline_if bm ();

   ctrl_pipeline #(.WIDTH(32), .ALU_CTRL_W(4), .ENABLE_M(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   ctrl_pipeline #(.WIDTH(32), .ALU_CTRL_W(4), .ENABLE_M(1'b1)) dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bm)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] get_obs(input logic sel, input fld_e f);
      logic [7:0] r;
      r = 8'd0;
      case (f)
         F_IMM:     r[2:0] = sel ? bm.imm_src_d    : b0.imm_src_d;
         F_ALU:     r[3:0] = sel ? bm.alu_ctrl_e   : b0.alu_ctrl_e;
         F_ALU_SRC: r[0]   = sel ? bm.alu_src_e    : b0.alu_src_e;
         F_ATYPE:   r[0]   = sel ? bm.a_type_e     : b0.a_type_e;
         F_JSRC:    r[0]   = sel ? bm.jump_src_e   : b0.jump_src_e;
         F_BR:      r[0]   = sel ? bm.branch_e     : b0.branch_e;
         F_JMP:     r[0]   = sel ? bm.jump_e       : b0.jump_e;
         F_F3:      r[2:0] = sel ? bm.funct3_e     : b0.funct3_e;
         F_MW:      r[0]   = sel ? bm.mem_write_m  : b0.mem_write_m;
         F_RS:      r[1:0] = sel ? bm.result_src_w : b0.result_src_w;
         F_RW:      r[0]   = sel ? bm.reg_write_w  : b0.reg_write_w;
         F_STF:     r[0]   = sel ? bm.stall_f      : b0.stall_f;
         F_STD:     r[0]   = sel ? bm.stall_d      : b0.stall_d;
         F_FLD:     r[0]   = sel ? bm.flush_d      : b0.flush_d;
         F_FLE:     r[0]   = sel ? bm.flush_e      : b0.flush_e;
         F_FWA:     r[1:0] = sel ? bm.forward_a_e  : b0.forward_a_e;
         F_FWB:     r[1:0] = sel ? bm.forward_b_e  : b0.forward_b_e;
         default:   r[0]   = sel ? bm.illegal_e    : b0.illegal_e;
      endcase
      return r;
   endfunction

   task automatic want(input int off, input logic sel, input fld_e f, input int v);
      item_t it;
      it.due = cyc + off;
      it.sel = sel;
      it.fld = f;
      it.exp = v[7:0];
      sb.push_back(it);
   endtask

   task automatic compare(input item_t it);
      logic [7:0] obs;
      obs = get_obs(it.sel, it.fld);
      checks++;
      assert (obs === it.exp) passed++;
      else $error("FAIL %s dut%0d cycle %0d: observed %0d expected %0d",
                  it.fld.name(), it.sel, cyc, obs, it.exp);
   endtask

   task automatic check_due();
      item_t keep[$];
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].due == cyc) compare(sb[i]);
         else keep.push_back(sb[i]);
      end
      sb = keep;
   endtask

   task automatic drive(input logic [31:0] instr, input logic pc_src);
      b0.instr_d  = instr;
      bm.instr_d  = instr;
      b0.pc_src_e = pc_src;
      bm.pc_src_e = pc_src;
   endtask

   task automatic tick();
      @(negedge clk);
      check_due();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(I_ADD_X3, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      // reset state, add x3 entering the pipe
      for (int f = int'(F_ALU); f <= int'(F_ILL); f++) want(0, 1'b0, fld_e'(f), 0);
      want(0, 1'b0, F_IMM, 0);
      want(1, 1'b0, F_ALU, 0);
      want(1, 1'b0, F_ALU_SRC, 0);
      want(3, 1'b0, F_RW, 1);
      want(3, 1'b0, F_RS, 0);
      tick();

      // lw x5 then dependent add x6: one stall cycle, then WB forward
      drive(I_LW_X5, 1'b0);
      want(0, 1'b0, F_STF, 0);
      want(1, 1'b0, F_ALU_SRC, 1);
      want(1, 1'b0, F_F3, 2);
      want(1, 1'b0, F_STF, 1);
      want(1, 1'b0, F_STD, 1);
      want(1, 1'b0, F_FLE, 1);
      want(1, 1'b0, F_FLD, 0);
      tick();
      drive(I_ADD_X6, 1'b0);
      want(1, 1'b0, F_STF, 0);
      want(1, 1'b0, F_FLE, 0);
      want(2, 1'b0, F_FWA, 1);
      want(2, 1'b0, F_FWB, 0);
      tick();
      tick();

      // back-to-back dependency -> MEM forward on both operands
      drive(I_ADD_X4, 1'b0);
      tick();
      drive(I_SUB_X7, 1'b0);
      want(0, 1'b0, F_STF, 0);
      want(1, 1'b0, F_FWA, 2);
      want(1, 1'b0, F_FWB, 2);
      want(1, 1'b0, F_ALU, 1);
      tick();

      // one nop in between -> WB forward
      drive(I_ADD_X4, 1'b0);
      tick();
      drive(I_NOP, 1'b0);
      tick();
      drive(I_SUB_X7, 1'b0);
      want(1, 1'b0, F_FWA, 1);
      want(1, 1'b0, F_FWB, 1);
      tick();

      // taken branch flushes the younger add
      drive(I_BEQ, 1'b0);
      want(0, 1'b0, F_IMM, 2);
      want(1, 1'b0, F_BR, 1);
      want(1, 1'b0, F_ALU, 1);
      want(1, 1'b0, F_ALU_SRC, 0);
      tick();
      drive(I_ADD_X9, 1'b1);
      want(0, 1'b0, F_FLD, 1);
      want(0, 1'b0, F_FLE, 1);
      want(0, 1'b0, F_STF, 0);
      want(1, 1'b0, F_BR, 0);
      want(1, 1'b0, F_JMP, 0);
      want(2, 1'b0, F_MW, 0);
      want(3, 1'b0, F_RW, 0);
      tick();

      // MUL legal only with ENABLE_M
      drive(I_MUL, 1'b0);
      want(1, 1'b0, F_ILL, 1);
      want(1, 1'b0, F_ALU, 0);
      want(1, 1'b1, F_ALU, 10);
      want(1, 1'b1, F_ILL, 0);
      want(3, 1'b0, F_RW, 0);
      want(3, 1'b1, F_RW, 1);
      tick();

      drive(I_SW, 1'b0);
      want(0, 1'b0, F_IMM, 1);
      want(1, 1'b0, F_ALU_SRC, 1);
      want(1, 1'b0, F_F3, 2);
      want(2, 1'b0, F_MW, 1);
      tick();
      drive(I_LUI, 1'b0);
      want(0, 1'b0, F_IMM, 4);
      want(1, 1'b0, F_ALU, 11);
      want(1, 1'b0, F_ALU_SRC, 1);
      tick();
      drive(I_JAL, 1'b0);
      want(0, 1'b0, F_IMM, 3);
      want(1, 1'b0, F_JMP, 1);
      want(1, 1'b0, F_JSRC, 0);
      want(3, 1'b0, F_RS, 2);
      tick();
      drive(I_JALR, 1'b0);
      want(1, 1'b0, F_JMP, 1);
      want(1, 1'b0, F_JSRC, 1);
      want(1, 1'b0, F_F3, 0);
      want(3, 1'b0, F_RS, 2);
      want(3, 1'b0, F_RW, 1);
      tick();
      drive(I_AUIPC, 1'b0);
      want(0, 1'b0, F_IMM, 4);
      want(1, 1'b0, F_ATYPE, 1);
      want(1, 1'b0, F_ALU, 0);
      tick();
      drive(I_BAD, 1'b0);
      want(1, 1'b0, F_ILL, 1);
      want(1, 1'b0, F_JMP, 0);
      want(2, 1'b0, F_MW, 0);
      tick();

      // x0 never forwards and never stalls
      drive(I_ADD_X0, 1'b0);
      tick();
      drive(I_ADD_X5Z, 1'b0);
      want(1, 1'b0, F_FWA, 0);
      want(1, 1'b0, F_FWB, 0);
      tick();
      drive(I_LW_X0, 1'b0);
      tick();
      drive(I_ADD_X6Z, 1'b0);
      want(0, 1'b0, F_STF, 0);
      want(0, 1'b0, F_FLE, 0);
      tick();

      // load-use coinciding with a flush: flush wins, no stall
      drive(I_LW_X5, 1'b0);
      tick();
      drive(I_ADD_X6, 1'b1);
      want(0, 1'b0, F_STF, 0);
      want(0, 1'b0, F_STD, 0);
      want(0, 1'b0, F_FLD, 1);
      want(0, 1'b0, F_FLE, 1);
      tick();

      // reset while sw is in EX discards it
      drive(I_SW, 1'b0);
      tick();
      drive(I_NOP, 1'b0);
      rst = 1'b1;
      want(1, 1'b0, F_MW, 0);
      want(1, 1'b0, F_ALU, 0);
      want(1, 1'b0, F_ILL, 0);
      want(1, 1'b0, F_RW, 0);
      tick();
      rst = 1'b0;

      repeat (5) tick();

      checks++;
      assert (sb.size() == 0) passed++;
      else $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
